ast_packet_arbiter: RTL

//  Packet-level round-robin arbiter sharing one Avalon-ST width converter input among NUM_SRC sources.

---
 rtl/ast_packet_arbiter_pkg.sv | 34 +++
 rtl/ast_packet_arbiter_rr_arbiter.sv | 43 ++++
 rtl/ast_packet_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ast_packet_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ast_packet_arbiter_pkg
// Purpose  : Shared types, default sizes and FSM encodings for the
//            Avalon-ST packet arbiter (ast_packet_arbiter) and its
//            round-robin sub-module.
// Contents : NUM_SRC / DATA_W / CHANNEL_W / EMPTY_W defaults,
//            channel_t, empty_in_t, src_idx_t, FSM state encodings,
//            idx_width() helper.
// Revision : 1.0 - initial release
// ============================================================================
package ast_packet_arbiter_pkg;

    localparam int NUM_SRC   = 4;
    localparam int DATA_W    = 64;
    localparam int CHANNEL_W = 10;
    localparam int EMPTY_W   = ($clog2(DATA_W/8) != 0) ? $clog2(DATA_W/8) : 1;

    typedef logic [CHANNEL_W-1:0]        channel_t;
    typedef logic [EMPTY_W-1:0]          empty_in_t;
    typedef logic [$clog2(NUM_SRC)-1:0]  src_idx_t;

    // Packet arbiter FSM: only two states, arbitration bubble then packet.
    localparam int               ST_W      = 1;
    localparam logic [ST_W-1:0]  c_st_idle = 1'b0;
    localparam logic [ST_W-1:0]  c_st_busy = 1'b1;

    // Width of a source index; never zero so vectors stay legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ast_packet_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ast_packet_arbiter_rr_arbiter
// Purpose  : Purely combinational round-robin selector. Scans requests
//            starting one past the last granted index and wrapping.
// Ports    : i_req        [NUM_SRC]  request vector (source valid)
//            i_last_grant [IDX_W]    index granted most recently
//            o_grant_idx  [IDX_W]    first requesting index after last grant
//            o_any_req               at least one request present
// Revision : 1.0 - initial release
// ============================================================================
module ast_packet_arbiter_rr_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_any_req
);

    int               w_idx;
    logic [IDX_W-1:0] w_sel;

    assign o_any_req = |i_req;

    // Walk offsets from farthest to nearest so the nearest requester
    // after the last grant is the one left in o_grant_idx.
    always_comb begin
        o_grant_idx = '0;
        w_idx       = 0;
        w_sel       = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            w_idx = (int'(i_last_grant) + k) % NUM_SRC;
            w_sel = IDX_W'(w_idx);
            if (i_req[w_sel]) begin
                o_grant_idx = w_sel;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ast_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ast_packet_arbiter
// Purpose  : Packet-level round-robin arbiter sharing one Avalon-ST width
//            converter input among NUM_SRC sources. A grant is taken in
//            IDLE (one bubble cycle) and held until the granted source's
//            eop beat handshakes.
// Ports    : clk_i, rst_i (async, active-high)
//            src_*_i / src_ready_o   per-source Avalon-ST sink side
//            ast_*_o / ast_ready_i   towards the converter sink port
//            grant_idx_o             current / last granted source
// Macro    : AST_ARB_CHANNEL_TAG_EN - when defined, ast_channel_o carries
//            the low source channel bits with the source index appended
//            in the LSBs (needs CHANNEL_W > index width).
// Revision : 1.0 - initial release
// ============================================================================
module ast_packet_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int DATA_W    = 64,
    parameter int CHANNEL_W = 10,
    parameter int EMPTY_W   = ($clog2(DATA_W/8) != 0) ? $clog2(DATA_W/8) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_SRC*DATA_W-1:0]      src_data_i,
    input  logic [NUM_SRC-1:0]             src_startofpacket_i,
    input  logic [NUM_SRC-1:0]             src_endofpacket_i,
    input  logic [NUM_SRC-1:0]             src_valid_i,
    input  logic [NUM_SRC*EMPTY_W-1:0]     src_empty_i,
    input  logic [NUM_SRC*CHANNEL_W-1:0]   src_channel_i,
    output logic [NUM_SRC-1:0]             src_ready_o,
    output logic [DATA_W-1:0]              ast_data_o,
    output logic                           ast_startofpacket_o,
    output logic                           ast_endofpacket_o,
    output logic                           ast_valid_o,
    output logic [EMPTY_W-1:0]             ast_empty_o,
    output logic [CHANNEL_W-1:0]           ast_channel_o,
    input  logic                           ast_ready_i,
    output logic [$clog2(NUM_SRC)-1:0]     grant_idx_o
);

    import ast_packet_arbiter_pkg::*;

    localparam int IDX_W = idx_width(NUM_SRC);

    // ---------------------------------------------------------------
    // Per-source field views
    // ---------------------------------------------------------------
    logic [DATA_W-1:0]    w_src_data    [NUM_SRC];
    logic [EMPTY_W-1:0]   w_src_empty   [NUM_SRC];
    logic [CHANNEL_W-1:0] w_src_channel [NUM_SRC];

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign w_src_data[gi]    = src_data_i[gi*DATA_W +: DATA_W];
            assign w_src_empty[gi]   = src_empty_i[gi*EMPTY_W +: EMPTY_W];
            assign w_src_channel[gi] = src_channel_i[gi*CHANNEL_W +: CHANNEL_W];
        end
    endgenerate

    // ---------------------------------------------------------------
    // State and grant registers
    // ---------------------------------------------------------------
    logic [ST_W-1:0]  r_state;
    logic [ST_W-1:0]  w_state_nxt;
    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] w_grant_nxt;
    logic [IDX_W-1:0] r_last_grant;
    logic [IDX_W-1:0] w_last_grant_nxt;
    logic [IDX_W-1:0] w_arb_idx;
    logic             w_any_req;
    logic             w_eop_xfer;

    logic [CHANNEL_W-1:0] w_grant_channel;
    logic [CHANNEL_W-1:0] w_chan_out;

    ast_packet_arbiter_rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .i_req        (src_valid_i),
        .i_last_grant (r_last_grant),
        .o_grant_idx  (w_arb_idx),
        .o_any_req    (w_any_req)
    );

    assign w_grant_channel = w_src_channel[r_grant];

`ifdef AST_ARB_CHANNEL_TAG_EN
    // Source index goes into the LSBs; the top IDX_W source bits fall off.
    assign w_chan_out = {w_grant_channel[CHANNEL_W-1-IDX_W:0], r_grant};
`else
    assign w_chan_out = w_grant_channel;
`endif

    assign w_eop_xfer  = src_valid_i[r_grant] & ast_ready_i & src_endofpacket_i[r_grant];
    assign grant_idx_o = r_grant;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= c_st_idle;
            r_grant      <= '0;
            // Start just before source 0 so it wins the first arbitration.
            r_last_grant <= IDX_W'(NUM_SRC - 1);
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    // ---------------------------------------------------------------
    // Next-state and output mux
    // ---------------------------------------------------------------
    always_comb begin
        w_state_nxt         = r_state;
        w_grant_nxt         = r_grant;
        w_last_grant_nxt    = r_last_grant;
        src_ready_o         = '0;
        ast_valid_o         = 1'b0;
        ast_data_o          = '0;
        ast_startofpacket_o = 1'b0;
        ast_endofpacket_o   = 1'b0;
        ast_empty_o         = '0;
        ast_channel_o       = '0;

        case (r_state)
            c_st_idle: begin
                if (w_any_req) begin
                    w_grant_nxt = w_arb_idx;
                    w_state_nxt = c_st_busy;
                end
            end
            c_st_busy: begin
                src_ready_o[r_grant] = ast_ready_i;
                ast_valid_o          = src_valid_i[r_grant];
                // Payload is zeroed whenever the granted source has no beat.
                if (src_valid_i[r_grant]) begin
                    ast_data_o          = w_src_data[r_grant];
                    ast_startofpacket_o = src_startofpacket_i[r_grant];
                    ast_endofpacket_o   = src_endofpacket_i[r_grant];
                    ast_empty_o         = w_src_empty[r_grant];
                    ast_channel_o       = w_chan_out;
                end
                if (w_eop_xfer) begin
                    w_last_grant_nxt = r_grant;
                    w_state_nxt      = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

endmodule
`default_nettype wire
